// File: rtl/ofifo_psum_writeback.sv
// Drains psum rows from the OFIFO into pmem. Each row either overwrites its pmem row or is
// added lane-wise to the stored partial sum; an optional ReLU is applied on the written value.
module ofifo_psum_writeback #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_bw = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_bw-1:0]       num_rows,
    input  logic [addr_bw-1:0]       base_addr,
    input  logic                     acc_mode,
    input  logic                     relu_en,
    input  logic                     ofifo_valid,
    input  logic [col*psum_bw-1:0]   ofifo_out,
    output logic                     ofifo_rd,
    input  logic [col*psum_bw-1:0]   pmem_q,
    output logic                     pmem_cen,
    output logic                     pmem_wen,
    output logic [addr_bw-1:0]       pmem_addr,
    output logic [col*psum_bw-1:0]   pmem_d,
    output logic                     busy,
    output logic                     done
);
    localparam int RW = col * psum_bw;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_RDWAIT = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             state_reg, state_next;
    logic [addr_bw-1:0] cnt_reg, cnt_next;
    logic [addr_bw-1:0] num_rows_reg, num_rows_next;
    logic [addr_bw-1:0] base_reg, base_next;
    logic               acc_reg, acc_next;
    logic               relu_reg, relu_next;
    logic [RW-1:0]      buf_reg, buf_next;

    logic [RW-1:0]      sum_row;
    logic [RW-1:0]      wr_row;
    logic [addr_bw-1:0] row_addr;
    logic               last_row;

    // Lane add wraps at psum_bw; ReLU only shapes the write data, never the buffer.
    genvar gi;
    generate
        for (gi = 0; gi < col; gi++) begin : g_lane
            logic [psum_bw-1:0] buf_lane;
            assign buf_lane = buf_reg[gi*psum_bw +: psum_bw];
            assign sum_row[gi*psum_bw +: psum_bw] = buf_lane + pmem_q[gi*psum_bw +: psum_bw];
            assign wr_row[gi*psum_bw +: psum_bw]  =
                (relu_reg && buf_lane[psum_bw-1]) ? '0 : buf_lane;
        end
    endgenerate

    assign row_addr = base_reg + cnt_reg;
    assign last_row = (cnt_reg == num_rows_reg - addr_bw'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            num_rows_reg <= '0;
            base_reg     <= '0;
            acc_reg      <= 1'b0;
            relu_reg     <= 1'b0;
            buf_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            num_rows_reg <= num_rows_next;
            base_reg     <= base_next;
            acc_reg      <= acc_next;
            relu_reg     <= relu_next;
            buf_reg      <= buf_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        num_rows_next = num_rows_reg;
        base_next     = base_reg;
        acc_next      = acc_reg;
        relu_next     = relu_reg;
        buf_next      = buf_reg;
        ofifo_rd      = 1'b0;
        pmem_cen      = 1'b1;
        pmem_wen      = 1'b1;
        pmem_addr     = '0;
        pmem_d        = '0;
        busy          = (state_reg != S_IDLE);
        done          = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    num_rows_next = num_rows;
                    base_next     = base_addr;
                    acc_next      = acc_mode;
                    relu_next     = relu_en;
                    cnt_next      = '0;
                    state_next    = (num_rows == '0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (ofifo_valid) begin
                    ofifo_rd = 1'b1;
                    buf_next = ofifo_out;
                    if (acc_reg) begin
                        // Read of the stored psum overlaps the pop; data lands in RDWAIT.
                        pmem_cen   = 1'b0;
                        pmem_addr  = row_addr;
                        state_next = S_RDWAIT;
                    end else begin
                        state_next = S_WRITE;
                    end
                end
            end
            S_RDWAIT: begin
                buf_next   = sum_row;
                state_next = S_WRITE;
            end
            S_WRITE: begin
                pmem_cen  = 1'b0;
                pmem_wen  = 1'b0;
                pmem_addr = row_addr;
                pmem_d    = wr_row;
                if (last_row) begin
                    state_next = S_DONE;
                end else begin
                    cnt_next   = cnt_reg + addr_bw'(1);
                    state_next = S_WAIT;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end
endmodule
